// File: rtl/fp_pkg.sv
// fp_pkg: shared float32 constants and the accumulator state type.
//   FP32_W        - float32 word width
//   FP32_POS_ZERO - +0.0 bit pattern, the accumulator's cleared value
//   FP32_ONE      - 1.0 bit pattern
//   accum_state_e - IDLE (no partial sum), ACCUM (summing), DONE (result held)
package fp_pkg;

  localparam int FP32_W = 32;

  localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_ONE      = 32'h3F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } accum_state_e;

endpackage

// File: rtl/FAdd.sv
// FAdd: combinational IEEE-754 single-precision adder, round-to-nearest-even.
//   a      - float32 operand
//   b      - float32 operand
//   answer - float32 a+b; any NaN input or +inf + -inf gives quiet NaN 7FC00000,
//            overflow gives a signed infinity, denormals are fully supported.
module FAdd (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] answer
);

  logic        sa, sb, sl;
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf, swap;
  logic [9:0]  exa, exb, el, es, dexp;
  logic [23:0] siga, sigb, sigl, sigs;
  logic [50:0] wide;
  logic [26:0] lg, sm, norm;
  logic [27:0] raw;
  logic [9:0]  e_norm, e_fin;
  logic [4:0]  lz, sh;
  logic        round_up;
  logic [24:0] rounded;
  logic [23:0] mant_fin;

  // Number of leading zeros in a 27-bit value (27 when the value is zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Align the smaller-magnitude operand to the larger one, add or subtract
  // with guard/round/sticky bits, renormalise (stopping at the denormal
  // boundary), then round to nearest even.
  always_comb begin
    sa = a[31];
    ea = a[30:23];
    ma = a[22:0];
    sb = b[31];
    eb = b[30:23];
    mb = b[22:0];

    a_nan = (ea == 8'hFF) && (ma != 23'd0);
    b_nan = (eb == 8'hFF) && (mb != 23'd0);
    a_inf = (ea == 8'hFF) && (ma == 23'd0);
    b_inf = (eb == 8'hFF) && (mb == 23'd0);

    // Denormals behave as exponent 1 without the hidden bit.
    exa  = (ea == 8'd0) ? 10'd1 : {2'b00, ea};
    exb  = (eb == 8'd0) ? 10'd1 : {2'b00, eb};
    siga = {ea != 8'd0, ma};
    sigb = {eb != 8'd0, mb};

    swap = {ea, ma} < {eb, mb};
    sl   = swap ? sb : sa;
    el   = swap ? exb : exa;
    es   = swap ? exa : exb;
    sigl = swap ? sigb : siga;
    sigs = swap ? siga : sigb;
    dexp = el - es;

    lg   = {sigl, 3'b000};
    wide = {sigs, 27'd0} >> dexp;
    if (dexp > 10'd26) begin
      sm = {26'd0, |sigs};
    end else begin
      sm = {wide[50:25], |wide[24:0]};
    end

    if (sa == sb) begin
      raw = {1'b0, lg} + {1'b0, sm};
    end else begin
      raw = {1'b0, lg} - {1'b0, sm};
    end

    lz     = lzc27(raw[26:0]);
    sh     = 5'd0;
    norm   = raw[26:0];
    e_norm = el;
    if (raw[27]) begin
      norm   = {raw[27:2], raw[1] | raw[0]};
      e_norm = el + 10'd1;
    end else begin
      // Never shift below exponent 1: what is left over is a denormal.
      sh     = ({5'd0, lz} < el) ? lz : 5'(el - 10'd1);
      norm   = raw[26:0] << sh;
      e_norm = el - {5'd0, sh};
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};
    mant_fin = rounded[23:0];
    e_fin    = e_norm;
    if (rounded[24]) begin
      mant_fin = rounded[24:1];
      e_fin    = e_norm + 10'd1;
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      answer = 32'h7FC0_0000;
    end else if (a_inf) begin
      answer = a;
    end else if (b_inf) begin
      answer = b;
    end else if (raw == 28'd0) begin
      // Exact zero is -0 only when both inputs were -0.
      answer = {sa & sb, 31'd0};
    end else if (e_fin >= 10'd255) begin
      answer = {sl, 8'hFF, 23'd0};
    end else begin
      answer = {sl, mant_fin[23] ? e_fin[7:0] : 8'd0, mant_fin[22:0]};
    end
  end

endmodule

// File: rtl/fadd_accum.sv
// fadd_accum: streaming float32 accumulator in front of FAdd.
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - operand handshake; in_data operand, in_last ends stream
//   out_valid/out_ready   - result handshake
//   out_sum               - float32 sum of the stream in arrival order
//   out_count             - accepted operand count, saturating at 2^CNT_W-1
//   count_sat             - stream was longer than 2^CNT_W-1
module fadd_accum
  import fp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP32_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP32_W-1:0] out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              count_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  accum_state_e      state, state_next;
  logic [FP32_W-1:0] acc, acc_next, fadd_sum;
  logic [CNT_W-1:0]  count, count_next;
  logic              sat, sat_next;
  logic              in_fire, out_fire;

  FAdd u_fadd (acc, in_data, fadd_sum);

  // The handshakes are forced low while reset is held so nothing is accepted
  // or presented during the reset cycle itself.
  assign in_ready  = rst_n && (state != DONE);
  assign out_valid = rst_n && (state == DONE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign out_sum   = out_valid ? acc : FP32_POS_ZERO;
  assign out_count = out_valid ? count : '0;
  assign count_sat = rst_n && sat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= FP32_POS_ZERO;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      count <= count_next;
      sat   <= sat_next;
    end
  end

  // The first operand of a stream is loaded raw rather than added to zero,
  // so -0, NaN payloads and denormals survive bit-exact.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    sat_next   = sat;
    case (state)
      IDLE: begin
        if (in_fire) begin
          acc_next   = in_data;
          count_next = CNT_W'(1);
          state_next = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_next = fadd_sum;
          if (count == CNT_MAX) begin
            sat_next = 1'b1;
          end else begin
            count_next = count + CNT_W'(1);
          end
          state_next = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_fire) begin
          acc_next   = FP32_POS_ZERO;
          count_next = '0;
          sat_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fadd_accum.sv
// tb_fadd_accum: scoreboard bench for fadd_accum (CNT_W=2 so saturation is
// reachable). The driver pushes the expected result of each stream, computed
// with real arithmetic on exactly representable values; an independent
// monitor pops and compares whenever a result is presented.
module tb_fadd_accum;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_data = 32'd0;
  logic             in_ready, out_valid, count_sat;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;

  typedef struct {
    logic [31:0] sum;
    int          count;
    bit          sat;
    longint      acceptEdge;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] curOps[$];
  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  int          stallLeft = 0;
  bit          randomReady = 1'b0;
  bit          seen = 1'b0;
  bit          idleNext = 1'b0;
  logic [31:0] heldSum;
  logic [CNT_W-1:0] heldCnt;
  logic        heldSat;

  fadd_accum #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .count_sat (count_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  // Normal numbers and zero only; that is all the stimulus produces.
  function automatic real f32ToReal(input logic [31:0] f);
    real m;
    if (f[30:0] == 31'd0) return 0.0;
    m = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] realToF32(input real v);
    real  m;
    int   e;
    logic s;
    if (v == 0.0) return 32'h0000_0000;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Expected result of the stream just closed: a lone operand passes
  // through untouched, otherwise the exact real sum.
  task automatic pushExpected(input longint lastEdge);
    real  total = 0.0;
    exp_t e;
    foreach (curOps[i]) total += f32ToReal(curOps[i]);
    e.sum        = (curOps.size() == 1) ? curOps[0] : realToF32(total);
    e.count      = (curOps.size() > CNT_MAX) ? CNT_MAX : curOps.size();
    e.sat        = (curOps.size() > CNT_MAX);
    e.acceptEdge = lastEdge;
    sb.push_back(e);
    curOps.delete();
  endtask

  // Offer one operand and hold it until accepted; entered and left just
  // after a rising edge.
  task automatic applyStimulus(input logic [31:0] d, input logic last);
    bit     ok = 1'b0;
    int     budget = 0;
    longint edgeNo = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!ok && budget < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok     = 1'b1;
        edgeNo = cyc + 1;
      end
      budget++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom);
    if (!ok) timeoutFail("in_accept");
    else begin
      curOps.push_back(d);
      if (last) pushExpected(edgeNo);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int budget = 0;
    while ((sb.size() != 0 || out_valid) && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 300) timeoutFail("drain");
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each presented result once, checks it is held while
  // stalled, and checks the block is back in IDLE after the handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_sum", out_sum, 32'd0);
        checkOutput("reset_out_count", 32'(out_count), 32'd0);
        seen     = 1'b0;
        idleNext = 1'b0;
      end else if (idleNext) begin
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
        idleNext = 1'b0;
      end else if (out_valid) begin
        checkOutput("done_in_ready", 32'(in_ready), 32'd0);
        if (!seen) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_output", 32'(out_valid), 32'd0);
          end else begin
            cur = sb.pop_front();
            checkOutput("out_sum", out_sum, cur.sum);
            checkOutput("out_count", 32'(out_count), 32'(cur.count));
            checkOutput("count_sat", 32'(count_sat), 32'(cur.sat));
            checkOutput("latency", 32'(cyc), 32'(cur.acceptEdge));
          end
          seen    = 1'b1;
          heldSum = out_sum;
          heldCnt = out_count;
          heldSat = count_sat;
        end else begin
          checkOutput("hold_out_sum", out_sum, heldSum);
          checkOutput("hold_out_count", 32'(out_count), 32'(heldCnt));
          checkOutput("hold_count_sat", 32'(count_sat), 32'(heldSat));
        end
        if (stallLeft > 0) begin
          out_ready = 1'b0;
          stallLeft--;
        end else begin
          out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) begin
          seen     = 1'b0;
          idleNext = 1'b1;
        end
      end else begin
        out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin
    int  n;
    real v;
    $display("[TB] starting fadd_accum bench");
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1 + 2 + 3 = 6.0, back to back
    applyStimulus(32'h3F80_0000, 1'b0);
    applyStimulus(32'h4000_0000, 1'b0);
    applyStimulus(32'h4040_0000, 1'b1);

    // single-operand streams pass through bit-exact, including -0
    applyStimulus(32'hBF80_0000, 1'b1);
    applyStimulus(32'h8000_0000, 1'b1);

    // result held under five cycles of backpressure
    drain();
    stallLeft = 5;
    applyStimulus(32'h3F80_0000, 1'b0);
    applyStimulus(32'h3F80_0000, 1'b1);

    // gaps in in_valid: 2 + 3 = 5.0
    applyStimulus(32'h4000_0000, 1'b0);
    idleCycles(3);
    applyStimulus(32'h4040_0000, 1'b1);

    // five ones overflow a 2-bit counter, then a fresh one-element stream
    repeat (4) applyStimulus(32'h3F80_0000, 1'b0);
    applyStimulus(32'h3F80_0000, 1'b1);
    applyStimulus(32'h3F80_0000, 1'b1);

    // reset mid-stream discards the partial sum
    drain();
    applyStimulus(32'h4000_0000, 1'b0);
    applyStimulus(32'h4000_0000, 1'b0);
    rst_n = 1'b0;
    curOps.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(32'h4040_0000, 1'b1);

    // random streams of quarter-valued operands with gaps and random out_ready
    drain();
    randomReady = 1'b1;
    for (int s = 0; s < 40; s++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        idleCycles($urandom_range(0, 2));
        v = (real'($urandom_range(0, 8000)) - 4000.0) / 4.0;
        applyStimulus(realToF32(v), (i == n - 1));
      end
    end

    drain();
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fadd_accum.md
Name: fadd_accum

Overview:
- Streaming IEEE-754 single-precision accumulator that sits directly upstream of the FAdd float adder. It feeds FAdd's `a`/`b` inputs and registers FAdd's `answer`.
- Accepts a valid/ready stream of float32 operands terminated by `in_last`, sums them one element per cycle, then presents the total and element count on a valid/ready output.
- Used to exercise FAdd sequentially and as the reduction stage for dot-product style datapaths.

Parameters:
- CNT_W, 8, width of the element counter; count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  32  float32 operand.
- in_last  input  1  qualifies the final operand of a stream; sampled only on handshake.
- out_valid  output  1  sum available.
- out_ready  input  1  consumer accepts sum.
- out_sum  output  32  float32 total.
- out_count  output  CNT_W  number of accepted operands, saturating.
- count_sat  output  1  stream length exceeded 2^CNT_W-1.

Behaviour:
- Reset, clk-synchronous while rst_n==0:
  - state=IDLE, acc=32'h0000_0000, count=0, count_sat=0.
  - out_valid=0, out_sum=0, out_count=0, in_ready=0 during reset.
  - in_ready=1 from the first cycle after release.
- Handshakes:
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
  - in_ready is combinational from state only: 1 in IDLE and ACCUM, 0 in DONE.
  - in_data and in_last are ignored when no transfer occurs; gaps in in_valid are allowed.
- States:
  - IDLE: no partial sum. On transfer: acc<=in_data loaded directly, bypassing FAdd so -0, NaN payloads and denormals pass bit-exact; count<=1. If in_last is also set, go DONE; otherwise go ACCUM.
  - ACCUM: on transfer: acc<=FAdd(acc,in_data) with FAdd a=acc, b=in_data; count<=sat(count+1). If in_last, go DONE; otherwise stay.
  - DONE: out_valid=1, out_sum=acc, out_count=count. Outputs are held stable until the output transfer. On transfer: acc<=0, count<=0, count_sat<=0, go IDLE.
- Latency:
  - The last operand is accepted in cycle N; out_valid=1 in cycle N+1.
  - Minimum stream-to-stream bubble is 1 cycle: the DONE handshake cycle. IDLE is entered on the cycle after it.
- Throughput: one operand per cycle in IDLE/ACCUM.
- Counter: when count==2^CNT_W-1 and another operand is accepted, count holds and count_sat<=1 (sticky until the DONE handshake). Summation is unaffected.
- Arithmetic: all rounding, special-value and exception semantics are those of FAdd. This block adds none and applies no reordering; summation is strictly in arrival order.
- in_valid while in DONE: not accepted; the upstream source must hold it.
- Reset mid-stream or in DONE: the partial sum is discarded and no output is produced. out_valid drops in the reset cycle.

Decomposition:
- Shared package fp_pkg:
  - FP32 width constant (32).
  - Constants FP32_POS_ZERO=32'h0000_0000 and FP32_ONE=32'h3F80_0000.
  - State enum {IDLE, ACCUM, DONE}.
- One sub-module: the existing FAdd, instanced unchanged with positional (a, b, answer).
- The accumulator register, counter and FSM stay in fadd_accum.

Test Plan:
- Stream 3F800000, 40000000, 40400000 (last on the third), in_valid continuous, out_ready=1 -> out_valid one cycle after the third operand, out_sum=40C00000 (6.0), out_count=3, count_sat=0.
- Single operand BF800000 with last, then separately 80000000 (-0) with last -> out_sum=BF800000 count=1, then out_sum=80000000 count=1 (bit-exact bypass).
- Backpressure: 3F800000, 3F800000(last), out_ready=0 for 5 cycles -> out_valid=1, in_ready=0, out_sum=40000000 stable all 5 cycles. out_ready=1 -> IDLE, in_ready=1 next cycle.
- Input gaps: 40000000, idle 3 cycles, 40400000(last) -> out_sum=40A00000 (5.0), out_count=2.
- Saturation, CNT_W=2: five operands of 3F800000, last on the fifth -> out_sum=40A00000, out_count=3, count_sat=1. The next stream of one 3F800000 -> count_sat=0, out_count=1.
- Reset mid-stream: two operands accepted, rst_n=0 for one cycle -> out_valid never asserts. After release, stream 40400000(last) -> out_sum=40400000, out_count=1.
